sdram_responder: RTL and testbench

//  Cycle-level SDR SDRAM device responder: decodes CKE/CS/RAS/CAS/WE, tracks the init sequence, mode register and per-bank open rows.

---
 rtl/sdram_responder_if.sv | 29 ++
 rtl/sdram_responder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_responder_if.sv
// Command/address/data bundle between an SDR SDRAM controller and the responder model.
// The DQ pad is split into dq_in/dq_out/dq_oe; the pad tristate lives at the top level.
interface sdram_responder_if #(
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = 13
);
    logic                     cke;
    logic                     cs_n;
    logic                     ras_n;
    logic                     cas_n;
    logic                     we_n;
    logic [BANK_WIDTH-1:0]    bank_addr;
    logic [SDRADDR_WIDTH-1:0] addr;
    logic                     dqm;
    logic [7:0]               dq_in;
    logic [7:0]               dq_out;
    logic                     dq_oe;

    // Handshake: no valid/ready; one command per clock, sampled on posedge when cke=1 and cs_n=0.
    modport master (
        output cke, cs_n, ras_n, cas_n, we_n, bank_addr, addr, dqm, dq_in,
        input  dq_out, dq_oe
    );

    modport slave (
        input  cke, cs_n, ras_n, cas_n, we_n, bank_addr, addr, dqm, dq_in,
        output dq_out, dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// Cycle-level SDR SDRAM device model: init tracking, mode register, per-bank open rows,
// single-beat x8 accesses into a small RAM, and a sticky first-violation flag.
module sdram_responder #(
    parameter int ROW_WIDTH     = 13,
    parameter int COL_WIDTH     = 10,
    parameter int BANK_WIDTH    = 2,
    parameter int SDRADDR_WIDTH = 13,
    parameter int MEM_ROW_BITS  = 4,
    parameter int MEM_COL_BITS  = 4,
    parameter int TRCD          = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sdram_responder_if.slave         io_sdram,
    output logic                     o_initialized,
    output logic [1:0]               o_cas_latency,
    output logic [15:0]              o_refresh_count,
    output logic                     o_protocol_error,
    output logic [2:0]               o_error_code,
    output logic [1:0]               o_init_state,
    output logic [SDRADDR_WIDTH-1:0] o_mode_reg
);

    localparam int NUM_BANKS = 1 << BANK_WIDTH;
    localparam int MEM_AW    = BANK_WIDTH + MEM_ROW_BITS + MEM_COL_BITS;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int TRCD_W    = $clog2(TRCD + 1);
    localparam logic [TRCD_W-1:0] TRCD_LOAD = TRCD_W'(TRCD - 1);

    // A misconfigured width set leaves the device deaf instead of silently aliasing addresses.
    localparam bit WIDTH_OK = (SDRADDR_WIDTH >= ROW_WIDTH) && (SDRADDR_WIDTH >= COL_WIDTH) &&
                              (ROW_WIDTH >= MEM_ROW_BITS) && (COL_WIDTH >= MEM_COL_BITS) &&
                              (SDRADDR_WIDTH > 10);

    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_BST   = 3'b110;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_MRS   = 3'b000;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_INIT     = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
    localparam logic [2:0] ERR_IDLE     = 3'd3;
    localparam logic [2:0] ERR_TRCD     = 3'd4;
    localparam logic [2:0] ERR_BUSY     = 3'd5;
    localparam logic [2:0] ERR_MODE     = 3'd6;

    typedef enum logic [1:0] {
        W_PRE = 2'd0,
        W_REF = 2'd1,
        W_MRS = 2'd2,
        READY = 2'd3
    } init_state_t;

    init_state_t r_state;
    init_state_t w_state_next;
    logic        r_init_ref;
    logic        w_init_ref_next;

    logic [NUM_BANKS-1:0]    r_bank_active;
    logic [MEM_ROW_BITS-1:0] r_open_row [NUM_BANKS];
    logic [TRCD_W-1:0]       r_trcd_cnt [NUM_BANKS];

    logic [1:0]               r_cas_latency;
    logic [SDRADDR_WIDTH-1:0] r_mode_reg;
    logic [15:0]              r_refresh_count;
    logic                     r_protocol_error;
    logic [2:0]               r_error_code;

    logic [7:0] r_mem [MEM_DEPTH];

    logic       r_p0_v, r_p1_v, r_p2_v;
    logic [7:0] r_p0_d, r_p1_d, r_p2_d;
    logic       r_dq_oe;
    logic [7:0] r_dq_out;

    logic                  w_is_nop;
    logic [2:0]            w_cmd;
    logic [BANK_WIDTH-1:0] w_bank;
    logic                  w_a10;
    logic                  w_bank_active;
    logic                  w_trcd_busy;
    logic                  w_any_active;
    logic [2:0]            w_cl_field;
    logic                  w_mode_ok;
    logic [MEM_AW-1:0]     w_mem_idx;
    logic [7:0]            w_rd_data;
    logic                  w_rd_launch;

    logic       w_do_act, w_do_read, w_do_write, w_do_pre, w_do_ref, w_do_mrs;
    logic [2:0] w_err;

    assign w_cmd         = {io_sdram.ras_n, io_sdram.cas_n, io_sdram.we_n};
    assign w_is_nop      = !WIDTH_OK || !io_sdram.cke || io_sdram.cs_n ||
                           (w_cmd == CMD_NOP) || (w_cmd == CMD_BST);
    assign w_bank        = io_sdram.bank_addr;
    assign w_a10         = io_sdram.addr[10];
    assign w_bank_active = r_bank_active[w_bank];
    assign w_trcd_busy   = (r_trcd_cnt[w_bank] != '0);
    assign w_any_active  = |r_bank_active;
    assign w_cl_field    = io_sdram.addr[6:4];
    assign w_mode_ok     = ((w_cl_field == 3'd2) || (w_cl_field == 3'd3)) &&
                           (io_sdram.addr[2:0] == 3'd0);
    assign w_mem_idx     = {w_bank, r_open_row[w_bank], io_sdram.addr[MEM_COL_BITS-1:0]};
    assign w_rd_data     = r_mem[w_mem_idx];
    assign w_rd_launch   = w_do_read && !io_sdram.dqm;

    always_comb begin
        w_state_next    = r_state;
        w_init_ref_next = r_init_ref;
        w_err           = ERR_NONE;
        w_do_act        = 1'b0;
        w_do_read       = 1'b0;
        w_do_write      = 1'b0;
        w_do_pre        = 1'b0;
        w_do_ref        = 1'b0;
        w_do_mrs        = 1'b0;
        if (!w_is_nop) begin
            case (r_state)
                W_PRE: begin
                    if (w_cmd == CMD_PRE && w_a10) w_state_next = W_REF;
                    else                           w_err        = ERR_INIT;
                end
                W_REF: begin
                    if (w_cmd == CMD_REF) begin
                        if (r_init_ref) begin
                            w_state_next    = W_MRS;
                            w_init_ref_next = 1'b0;
                        end else begin
                            w_init_ref_next = 1'b1;
                        end
                    end else begin
                        w_err = ERR_INIT;
                    end
                end
                W_MRS: begin
                    if (w_cmd == CMD_MRS) begin
                        w_state_next = READY;
                        w_do_mrs     = 1'b1;
                        if (!w_mode_ok) w_err = ERR_MODE;
                    end else begin
                        w_err = ERR_INIT;
                    end
                end
                READY: begin
                    case (w_cmd)
                        CMD_ACT: begin
                            if (w_bank_active) w_err    = ERR_ACT_OPEN;
                            else               w_do_act = 1'b1;
                        end
                        CMD_READ, CMD_WRITE: begin
                            if (!w_bank_active) begin
                                w_err = ERR_IDLE;
                            end else begin
                                w_do_read  = (w_cmd == CMD_READ);
                                w_do_write = (w_cmd == CMD_WRITE);
                                if (w_trcd_busy) w_err = ERR_TRCD;
                            end
                        end
                        CMD_PRE: w_do_pre = 1'b1;
                        CMD_REF: begin
                            if (w_any_active) w_err    = ERR_BUSY;
                            else              w_do_ref = 1'b1;
                        end
                        CMD_MRS: begin
                            if (w_any_active) begin
                                w_err = ERR_BUSY;
                            end else begin
                                w_do_mrs = 1'b1;
                                if (!w_mode_ok) w_err = ERR_MODE;
                            end
                        end
                        default: ;
                    endcase
                end
                default: w_state_next = W_PRE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= W_PRE;
            r_init_ref       <= 1'b0;
            r_cas_latency    <= 2'd2;
            r_mode_reg       <= '0;
            r_refresh_count  <= '0;
            r_protocol_error <= 1'b0;
            r_error_code     <= ERR_NONE;
        end else begin
            r_state    <= w_state_next;
            r_init_ref <= w_init_ref_next;
            if (w_do_mrs) begin
                r_mode_reg    <= io_sdram.addr;
                r_cas_latency <= w_mode_ok ? w_cl_field[1:0] : 2'd2;
            end
            if (w_do_ref) r_refresh_count <= r_refresh_count + 16'd1;
            if (w_err != ERR_NONE && !r_protocol_error) begin
                r_protocol_error <= 1'b1;
                r_error_code     <= w_err;
            end
        end
    end

    // Later assignments in this block override the per-cycle tRCD decrement and bank clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_active <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_open_row[b] <= '0;
                r_trcd_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_trcd_cnt[b] != '0) r_trcd_cnt[b] <= r_trcd_cnt[b] - TRCD_W'(1);
            end
            if (w_do_act) begin
                r_bank_active[w_bank] <= 1'b1;
                r_open_row[w_bank]    <= io_sdram.addr[MEM_ROW_BITS-1:0];
                r_trcd_cnt[w_bank]    <= TRCD_LOAD;
            end
            if ((w_do_read || w_do_write) && w_a10) r_bank_active[w_bank] <= 1'b0;
            if (w_do_pre) begin
                if (w_a10) r_bank_active          <= '0;
                else       r_bank_active[w_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_write && !io_sdram.dqm) r_mem[w_mem_idx] <= io_sdram.dq_in;
    end

    // CL=3 reads enter one stage earlier than CL=2 reads; both leave through the same output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_v   <= 1'b0;
            r_p1_v   <= 1'b0;
            r_p2_v   <= 1'b0;
            r_p0_d   <= '0;
            r_p1_d   <= '0;
            r_p2_d   <= '0;
            r_dq_oe  <= 1'b0;
            r_dq_out <= '0;
        end else begin
            r_p0_v   <= w_rd_launch && (r_cas_latency == 2'd3);
            r_p0_d   <= w_rd_data;
            r_p1_v   <= (w_rd_launch && (r_cas_latency == 2'd2)) || r_p0_v;
            r_p1_d   <= (w_rd_launch && (r_cas_latency == 2'd2)) ? w_rd_data : r_p0_d;
            r_p2_v   <= r_p1_v;
            r_p2_d   <= r_p1_d;
            r_dq_oe  <= r_p2_v;
            r_dq_out <= r_p2_v ? r_p2_d : 8'h00;
        end
    end

    assign io_sdram.dq_oe  = r_dq_oe;
    assign io_sdram.dq_out = r_dq_out;

    assign o_initialized    = (r_state == READY);
    assign o_cas_latency    = r_cas_latency;
    assign o_refresh_count  = r_refresh_count;
    assign o_protocol_error = r_protocol_error;
    assign o_error_code     = r_error_code;
    assign o_init_state     = r_state;
    assign o_mode_reg       = r_mode_reg;

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: drives SDRAM commands and checks against a command-level device model.
module tb_sdram_responder;

  localparam int TRCD = 2;
  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [12:0] A10 = 13'h400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_total = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  logic        initialized;
  logic [1:0]  cas_latency;
  logic [15:0] refresh_count;
  logic        protocol_error;
  logic [2:0]  error_code;
  logic [1:0]  init_state;
  logic [12:0] mode_reg;

  sdram_responder_if #(.BANK_WIDTH(2), .SDRADDR_WIDTH(13)) sd ();

  sdram_responder #(.TRCD(TRCD)) dut (
    .clk(clk), .rst_n(rst_n), .io_sdram(sd),
    .o_initialized(initialized), .o_cas_latency(cas_latency),
    .o_refresh_count(refresh_count), .o_protocol_error(protocol_error),
    .o_error_code(error_code), .o_init_state(init_state), .o_mode_reg(mode_reg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- reference model ----------------
  int m_stage, m_init_refs, m_err_code, m_cl, m_ref;
  bit m_open [4];
  int m_row [4];
  int m_act_edge [4];
  logic [7:0] m_mem [int];
  bit m_rd_known;
  logic [7:0] m_rd_data;

  task automatic model_reset();
    m_stage = 0; m_init_refs = 0; m_err_code = 0; m_cl = 2; m_ref = 0;
    for (int b = 0; b < 4; b++) begin m_open[b] = 0; m_row[b] = 0; m_act_edge[b] = -100; end
  endtask

  task automatic model_err(input int code);
    if (m_err_code == 0) m_err_code = code;
  endtask

  task automatic model_mode(input logic [12:0] a);
    int cl;
    cl = int'(a[6:4]);
    if ((cl == 2 || cl == 3) && a[2:0] == 3'd0) m_cl = cl;
    else begin m_cl = 2; model_err(6); end
  endtask

  task automatic model_cmd(input logic [2:0] c, input int b, input logic [12:0] a,
                           input bit dm, input logic [7:0] d);
    int e, idx;
    bit any_open;
    e = edge_cnt + 1;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    if (c == C_NOP || c == 3'b110) return;
    if (m_stage == 0) begin
      if (c == C_PRE && a[10]) m_stage = 1; else model_err(1);
    end else if (m_stage == 1) begin
      if (c == C_REF) begin m_init_refs++; if (m_init_refs == 2) m_stage = 2; end
      else model_err(1);
    end else if (m_stage == 2) begin
      if (c == C_MRS) begin m_stage = 3; model_mode(a); end else model_err(1);
    end else begin
      case (c)
        C_ACT: if (m_open[b]) model_err(2);
               else begin m_open[b] = 1; m_row[b] = int'(a[3:0]); m_act_edge[b] = e; end
        C_RD, C_WR: if (!m_open[b]) model_err(3);
          else begin
            if (e - m_act_edge[b] < TRCD) model_err(4);
            idx = b * 256 + m_row[b] * 16 + int'(a[3:0]);
            if (c == C_WR) begin
              if (!dm) m_mem[idx] = d;
            end else begin
              m_rd_known = m_mem.exists(idx);
              m_rd_data = m_rd_known ? m_mem[idx] : 8'h00;
            end
            if (a[10]) m_open[b] = 0;
          end
        C_PRE: if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0; else m_open[b] = 0;
        C_REF: if (any_open) model_err(5); else m_ref = (m_ref + 1) % 65536;
        C_MRS: if (any_open) model_err(5); else model_mode(a);
        default: ;
      endcase
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_nop();
    sd.cke = 1'b1; sd.cs_n = 1'b1; {sd.ras_n, sd.cas_n, sd.we_n} = C_NOP;
    sd.bank_addr = 2'd0; sd.addr = 13'd0; sd.dqm = 1'b0; sd.dq_in = 8'h00;
  endtask

  task automatic issue(input logic [2:0] c, input int b, input logic [12:0] a,
                       input bit dm, input logic [7:0] d);
    sd.cke = 1'b1; sd.cs_n = 1'b0; {sd.ras_n, sd.cas_n, sd.we_n} = c;
    sd.bank_addr = b[1:0]; sd.addr = a; sd.dqm = dm; sd.dq_in = d;
    model_cmd(c, b, a, dm, d);
  endtask

  task automatic step(input logic [2:0] c, input int b, input logic [12:0] a,
                      input bit dm, input logic [7:0] d);
    @(negedge clk);
    issue(c, b, a, dm, d);
  endtask

  task automatic settle();
    @(negedge clk);
    set_nop();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_nop();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_init();
    repeat (4) step(C_NOP, 0, 13'd0, 0, 8'h00);
    step(C_PRE, 0, A10, 0, 8'h00);
    step(C_REF, 0, 13'd0, 0, 8'h00);
    step(C_REF, 0, 13'd0, 0, 8'h00);
    step(C_MRS, 0, 13'h220, 0, 8'h00);
    settle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++; if (initialized !== 1'b0) begin n_bad++; $display("FAIL reset_init got=%b exp=0", initialized); end
    n_total++; if (cas_latency !== 2'd2) begin n_bad++; $display("FAIL reset_cl got=%0d exp=2", cas_latency); end
    n_total++; if (protocol_error !== 1'b0) begin n_bad++; $display("FAIL reset_perr got=%b exp=0", protocol_error); end
    n_total++; if (error_code !== 3'd0) begin n_bad++; $display("FAIL reset_code got=%0d exp=0", error_code); end
    n_total++; if (sd.dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got=%b exp=0", sd.dq_oe); end
    n_total++; if (refresh_count !== 16'd0) begin n_bad++; $display("FAIL reset_refcnt got=%0d exp=0", refresh_count); end
  endtask

  task automatic test_init();
    run_init();
    n_total++; if (initialized !== (m_stage == 3)) begin n_bad++; $display("FAIL init_done got=%b exp=%b", initialized, m_stage == 3); end
    n_total++; if (cas_latency !== m_cl[1:0]) begin n_bad++; $display("FAIL init_cl got=%0d exp=%0d", cas_latency, m_cl); end
    n_total++; if (error_code !== m_err_code[2:0]) begin n_bad++; $display("FAIL init_code got=%0d exp=%0d", error_code, m_err_code); end
    n_total++; if (protocol_error !== (m_err_code != 0)) begin n_bad++; $display("FAIL init_perr got=%b exp=%b", protocol_error, m_err_code != 0); end
  endtask

  task automatic test_refresh();
    repeat (3) step(C_REF, 0, 13'd0, 0, 8'h00);
    settle();
    n_total++; if (refresh_count !== m_ref[15:0]) begin n_bad++; $display("FAIL refresh_count got=%0d exp=%0d", refresh_count, m_ref); end
  endtask

  task automatic test_write_read();
    logic [7:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        step(C_MRS, 0, 13'h230, 0, 8'h00);
        settle();
        n_total++; if (cas_latency !== m_cl[1:0]) begin n_bad++; $display("FAIL wr_rd_cl got=%0d exp=%0d", cas_latency, m_cl); end
      end
      step(C_ACT, 1, 13'd3, 0, 8'h00);
      step(C_NOP, 0, 13'd0, 0, 8'h00);
      step(C_WR, 1, A10 | 13'd5, 0, 8'hA5);
      step(C_ACT, 1, 13'd3, 0, 8'h00);
      step(C_NOP, 0, 13'd0, 0, 8'h00);
      step(C_RD, 1, 13'd5, 0, 8'h00);
      exp = m_rd_data;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 0) set_nop();
        n_total++;
        if (sd.dq_oe !== (k == m_cl)) begin n_bad++; $display("FAIL wr_rd_oe cl=%0d k=%0d got=%b exp=%b", m_cl, k, sd.dq_oe, k == m_cl); end
        if (k == m_cl) begin
          n_total++;
          if (sd.dq_out !== exp) begin n_bad++; $display("FAIL wr_rd_data cl=%0d got=%h exp=%h", m_cl, sd.dq_out, exp); end
        end
      end
      step(C_PRE, 0, A10, 0, 8'h00);
    end
  endtask

  task automatic test_read_masked();
    step(C_ACT, 1, 13'd3, 0, 8'h00);
    step(C_NOP, 0, 13'd0, 0, 8'h00);
    step(C_RD, 1, A10 | 13'd5, 1, 8'h00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) set_nop();
      n_total++;
      if (sd.dq_oe !== 1'b0) begin n_bad++; $display("FAIL masked_oe k=%0d got=%b exp=0", k, sd.dq_oe); end
    end
  endtask

  task automatic test_random();
    int b, gap, col;
    logic [12:0] row;
    logic [7:0] d, exp;
    bit dm;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) step(C_MRS, 0, ($urandom_range(0, 1) == 1) ? 13'h230 : 13'h220, 0, 8'h00);
      b = $urandom_range(0, 3);
      row = 13'($urandom_range(0, 8191));
      col = $urandom_range(0, 1023);
      d = 8'($urandom_range(0, 255));
      dm = m_mem.exists(b * 256 + int'(row[3:0]) * 16 + (col % 16)) && ($urandom_range(0, 3) == 0);
      gap = $urandom_range(1, 3);
      step(C_ACT, b, row, 0, 8'h00);
      repeat (gap) step(C_NOP, 0, 13'd0, 0, 8'h00);
      step(C_WR, b, A10 | 13'(col), dm, d);
      step(C_ACT, b, row, 0, 8'h00);
      repeat (gap) step(C_NOP, 0, 13'd0, 0, 8'h00);
      step(C_RD, b, A10 | 13'(col), 0, 8'h00);
      exp = m_rd_data;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 0) set_nop();
        n_total++;
        if (sd.dq_oe !== (k == m_cl)) begin n_bad++; $display("FAIL rand_oe it=%0d k=%0d got=%b exp=%b", it, k, sd.dq_oe, k == m_cl); end
        if (k == m_cl) begin
          n_total++;
          if (sd.dq_out !== exp) begin n_bad++; $display("FAIL rand_data it=%0d got=%h exp=%h", it, sd.dq_out, exp); end
        end
      end
    end
    n_total++; if (error_code !== m_err_code[2:0]) begin n_bad++; $display("FAIL rand_code got=%0d exp=%0d", error_code, m_err_code); end
    n_total++; if (cas_latency !== m_cl[1:0]) begin n_bad++; $display("FAIL rand_cl got=%0d exp=%0d", cas_latency, m_cl); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1, d2, d3, exp1, exp2;
    d1 = 8'($urandom_range(0, 255));
    d2 = 8'($urandom_range(0, 255));
    d3 = ~d1;
    step(C_ACT, 2, 13'd7, 0, 8'h00);
    step(C_NOP, 0, 13'd0, 0, 8'h00);
    step(C_WR, 2, 13'd1, 0, d1);
    step(C_WR, 2, 13'd2, 0, d2);
    step(C_RD, 2, 13'd1, 0, 8'h00);
    exp1 = m_rd_data;
    exp2 = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin issue(C_RD, 2, 13'd2, 0, 8'h00); exp2 = m_rd_data; end
      else if (k == 1) issue(C_WR, 2, 13'd1, 0, d3);
      else if (k == 2) set_nop();
      n_total++;
      if (sd.dq_oe !== (k == m_cl || k == m_cl + 1)) begin n_bad++; $display("FAIL b2b_oe k=%0d got=%b exp=%b", k, sd.dq_oe, k == m_cl || k == m_cl + 1); end
      if (k == m_cl) begin
        n_total++; if (sd.dq_out !== exp1) begin n_bad++; $display("FAIL b2b_data1 got=%h exp=%h", sd.dq_out, exp1); end
      end
      if (k == m_cl + 1) begin
        n_total++; if (sd.dq_out !== exp2) begin n_bad++; $display("FAIL b2b_data2 got=%h exp=%h", sd.dq_out, exp2); end
      end
    end
    step(C_RD, 2, A10 | 13'd1, 0, 8'h00);
    exp1 = m_rd_data;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) set_nop();
      if (k == m_cl) begin
        n_total++; if (sd.dq_out !== exp1 || sd.dq_oe !== 1'b1) begin n_bad++; $display("FAIL b2b_rewrite got=%h oe=%b exp=%h", sd.dq_out, sd.dq_oe, exp1); end
      end
    end
  endtask

  task automatic test_errors();
    step(C_ACT, 0, 13'd0, 0, 8'h00);
    step(C_RD, 0, 13'd0, 0, 8'h00);
    settle();
    n_total++; if (error_code !== m_err_code[2:0]) begin n_bad++; $display("FAIL trcd_code got=%0d exp=%0d", error_code, m_err_code); end
    n_total++; if (protocol_error !== (m_err_code != 0)) begin n_bad++; $display("FAIL trcd_perr got=%b exp=%b", protocol_error, m_err_code != 0); end
    step(C_ACT, 2, 13'd0, 0, 8'h00);
    step(C_ACT, 2, 13'd0, 0, 8'h00);
    settle();
    n_total++; if (error_code !== m_err_code[2:0]) begin n_bad++; $display("FAIL sticky_code got=%0d exp=%0d", error_code, m_err_code); end
    do_reset();
    run_init();
    step(C_ACT, 0, 13'd0, 0, 8'h00);
    step(C_REF, 0, 13'd0, 0, 8'h00);
    settle();
    n_total++; if (error_code !== m_err_code[2:0]) begin n_bad++; $display("FAIL busy_ref_code got=%0d exp=%0d", error_code, m_err_code); end
    n_total++; if (refresh_count !== m_ref[15:0]) begin n_bad++; $display("FAIL busy_ref_cnt got=%0d exp=%0d", refresh_count, m_ref); end
    do_reset();
    step(C_NOP, 0, 13'd0, 0, 8'h00);
    step(C_ACT, 0, 13'd0, 0, 8'h00);
    settle();
    n_total++; if (error_code !== m_err_code[2:0]) begin n_bad++; $display("FAIL preinit_code got=%0d exp=%0d", error_code, m_err_code); end
    n_total++; if (initialized !== (m_stage == 3)) begin n_bad++; $display("FAIL preinit_init got=%b exp=%b", initialized, m_stage == 3); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    run_init();
    step(C_ACT, 3, 13'd1, 0, 8'h00);
    step(C_NOP, 0, 13'd0, 0, 8'h00);
    step(C_WR, 3, A10 | 13'd9, 0, 8'h5C);
    step(C_ACT, 3, 13'd1, 0, 8'h00);
    step(C_NOP, 0, 13'd0, 0, 8'h00);
    step(C_RD, 3, 13'd9, 0, 8'h00);
    settle();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++; if (sd.dq_oe !== 1'b0) begin n_bad++; $display("FAIL midrd_oe got=%b exp=0", sd.dq_oe); end
    n_total++; if (initialized !== 1'b0) begin n_bad++; $display("FAIL midrd_init got=%b exp=0", initialized); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_total++; if (sd.dq_oe !== 1'b0) begin n_bad++; $display("FAIL midrd_hold_oe k=%0d got=%b exp=0", k, sd.dq_oe); end
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++; if (sd.dq_oe !== 1'b0) begin n_bad++; $display("FAIL midrd_post_oe k=%0d got=%b exp=0", k, sd.dq_oe); end
    end
  endtask

  initial begin
    set_nop();
    model_reset();
    test_reset();
    test_init();
    test_refresh();
    test_write_read();
    test_read_masked();
    test_random();
    test_back_to_back();
    test_errors();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
